// File: rtl/uart_pkg.sv
// Shared UART transmitter types: FSM state encoding and serial line levels.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  localparam logic IDLE_BIT  = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Bit counter width; a 1-bit word still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/tx_parity_calc.sv
// Combinational parity of the latched word: even parity = XOR of data, odd = its inverse.
module tx_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_parity
);

  assign o_parity = (^i_data) ^ i_par_typ;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Macro UART_TX_STOP2_EN selects two stop bits instead of one.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy,
  output uart_state_t           o_dbg_state
);

  // Request handshake: DATA_VALID is a level request sampled only in IDLE;
  // the word and parity config are captured on the accepting edge and held
  // until the frame ends, so DATA_VALID and P_DATA are don't-care while Busy=1.

  localparam int CNT_W = int'(cnt_width(DATA_WIDTH));

  uart_state_t           r_state;
  logic                  r_tx;
  logic                  r_busy;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;

  logic                  w_parity;
  logic                  w_last_bit;
  logic [CNT_W-1:0]      w_next_idx;
  logic                  w_stop_done;

  tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .i_data    (r_data),
    .i_par_typ (r_par_typ),
    .o_parity  (w_parity)
  );

  assign w_last_bit = (r_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_next_idx = r_cnt + CNT_W'(1);

`ifdef UART_TX_STOP2_EN
  logic r_stop2;
  assign w_stop_done = r_stop2;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_stop2 <= 1'b0;
    end else if (r_state == ST_STOP) begin
      r_stop2 <= ~r_stop2;
    end else begin
      r_stop2 <= 1'b0;
    end
  end
`else
  assign w_stop_done = 1'b1;
`endif

  // TX_OUT is loaded with the level of the bit the next state will present.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_tx      <= IDLE_BIT;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (DATA_VALID) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_state   <= ST_START;
            r_tx      <= START_BIT;
            r_busy    <= 1'b1;
          end
        end
        ST_START: begin
          r_state <= ST_DATA;
          r_cnt   <= '0;
          r_tx    <= r_data[0];
        end
        ST_DATA: begin
          if (w_last_bit) begin
            if (r_par_en) begin
              r_state <= ST_PARITY;
              r_tx    <= w_parity;
            end else begin
              r_state <= ST_STOP;
              r_tx    <= STOP_BIT;
            end
          end else begin
            r_cnt <= w_next_idx;
            r_tx  <= r_data[w_next_idx];
          end
        end
        ST_PARITY: begin
          r_state <= ST_STOP;
          r_tx    <= STOP_BIT;
        end
        ST_STOP: begin
          if (w_stop_done) begin
            r_state <= ST_IDLE;
            r_tx    <= IDLE_BIT;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_tx <= STOP_BIT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= IDLE_BIT;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign TX_OUT      = r_tx;
  assign Busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: expected serial bits and frame lengths queued at request time, checked per cycle.
module tb_uart_tx;

`ifdef UART_TX_STOP2_EN
  localparam int STOP_N = 2;
`else
  localparam int STOP_N = 1;
`endif

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;
  logic [2:0] dbg_state;

  logic [0:0] exp_q[$];
  int         len_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       mon_en   = 1'b0;
  logic       abort    = 1'b0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .P_DATA      (P_DATA),
    .DATA_VALID  (DATA_VALID),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .TX_OUT      (TX_OUT),
    .Busy        (Busy),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard model: start, data LSB first, optional parity, stop bit(s)
  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back((^d) ^ pt);
    for (int i = 0; i < STOP_N; i++) exp_q.push_back(1'b1);
    len_q.push_back(1 + 8 + int'(pe) + STOP_N);
  endtask

  // monitor: samples on the falling edge
  initial begin
    logic prev_busy;
    int   busy_cnt;
    logic [0:0] b;
    prev_busy = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (Busy) begin
          busy_cnt++;
          if (exp_q.size() == 0) begin
            check("extra_bit", 32'(exp_q.size()), 32'd1);
          end else begin
            b = exp_q.pop_front();
            check("tx_bit", 32'(TX_OUT), 32'(b));
          end
        end else begin
          check("idle_tx", 32'(TX_OUT), 32'd1);
          if (prev_busy) begin
            if (abort) begin
              abort = 1'b0;
            end else if (len_q.size() == 0) begin
              check("busy_len_unexp", 32'(busy_cnt), 32'd0);
            end else begin
              check("busy_len", 32'(busy_cnt), 32'(len_q.pop_front()));
            end
          end
          busy_cnt = 0;
        end
        prev_busy = Busy;
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (Busy && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("frame_done", 32'(n < 40), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt);
    @(posedge CLK); #2;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
    push_frame(d, pe, pt);
    @(posedge CLK); #2;
    DATA_VALID = 1'b0;
    P_DATA     = 8'($urandom_range(0, 255));
    PAR_EN     = 1'($urandom_range(0, 1));
    PAR_TYP    = 1'($urandom_range(0, 1));
    // a stray request mid-frame must be ignored
    repeat (2) @(posedge CLK);
    #2 DATA_VALID = 1'b1;
    @(posedge CLK); #2;
    DATA_VALID = 1'b0;
    wait_idle();
  endtask

  initial begin
    RST        = 1'b0;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_tx", 32'(TX_OUT), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge CLK); #2;
    RST    = 1'b1;
    mon_en = 1'b1;

    // basic frame, no parity
    send(8'hA5, 1'b0, 1'b0);
    // even and odd parity
    send(8'hA5, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b1);

    // DATA_VALID held high, word changes mid-frame
    @(posedge CLK); #2;
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    DATA_VALID = 1'b1;
    push_frame(8'hA5, 1'b0, 1'b0);
    push_frame(8'h3C, 1'b0, 1'b0);
    @(posedge CLK);
    repeat (3) @(posedge CLK);
    #2 P_DATA = 8'h3C;
    repeat (9 + STOP_N - 3) @(posedge CLK);
    @(negedge CLK);
    check("b2b_gap_busy", 32'(Busy), 32'd0);
    check("b2b_gap_tx", 32'(TX_OUT), 32'd1);
    @(negedge CLK);
    check("b2b_restart_busy", 32'(Busy), 32'd1);
    check("b2b_restart_tx", 32'(TX_OUT), 32'd0);
    #1 DATA_VALID = 1'b0;
    wait_idle();

    // reset during data bit 3
    @(posedge CLK); #2;
    P_DATA     = 8'($urandom_range(0, 255));
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    DATA_VALID = 1'b1;
    push_frame(P_DATA, 1'b1, 1'b0);
    @(posedge CLK); #2;
    DATA_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK); #1;
    RST = 1'b0;
    exp_q.delete();
    len_q.delete();
    abort = 1'b1;
    @(negedge CLK);
    check("abort_tx", 32'(TX_OUT), 32'd1);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    #1 RST = 1'b1;
    repeat (4) @(negedge CLK);
    check("abort_no_resume", 32'(Busy), 32'd0);
    send(8'hFF, 1'b0, 1'b0);

    // odd parity on all-zero and all-one words
    send(8'h00, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);

    // random frames
    for (int k = 0; k < 8; k++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge CLK);
    check("drain_bits", 32'(exp_q.size()), 32'd0);
    check("drain_lens", 32'(len_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the parallel data word and the number of serial data bits.
REQ-002 SHALL have port CLK  input  1  bit clock; one serial bit is emitted per CLK cycle.
REQ-003 SHALL have port RST  input  1  synchronous, active-low reset.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel word to transmit.
REQ-005 SHALL have port DATA_VALID  input  1  request strobe; P_DATA is valid while high.
REQ-006 SHALL have port PAR_EN  input  1  inserts a parity bit when high.
REQ-007 SHALL have port PAR_TYP  input  1  parity type: 0 = even, 1 = odd.
REQ-008 SHALL have port TX_OUT  output  1  serial line, idle high.
REQ-009 SHALL have port Busy  output  1  high while a frame is on the line.

Function
REQ-010 SHALL implement an FSM with states IDLE, START, DATA, PARITY and STOP.
REQ-011 SHALL accept a request only in IDLE when DATA_VALID=1, latching P_DATA, PAR_EN and PAR_TYP in the same edge.
REQ-012 SHALL ignore DATA_VALID while Busy=1; latched values SHALL NOT change mid-frame.
REQ-013 SHALL produce a registered TX_OUT: start bit 0 in the cycle after acceptance, then DATA_WIDTH data bits LSB first, one per cycle.
REQ-014 SHALL emit, after the data bits, a parity bit only if the latched PAR_EN=1; the bit is XOR of the data for even parity and its inverse for odd parity.
REQ-015 SHALL emit one stop bit 1, then return to IDLE with TX_OUT=1.
REQ-016 SHALL assert a registered Busy from the start-bit cycle through the last stop-bit cycle inclusive; Busy SHALL be 0 in IDLE.
REQ-017 SHALL accept a new request in the first IDLE cycle after STOP, giving back-to-back frames one idle-high cycle apart.
REQ-018 SHALL use a bit counter of ceil(log2(DATA_WIDTH)) bits that clears on entry to DATA and SHALL leave DATA when the counter equals DATA_WIDTH-1.
REQ-019 SHALL make the frame length 2+DATA_WIDTH+PAR_EN cycles (+1 under REQ-023).

Reset
REQ-020 SHALL, when RST=0 at a CLK edge, set state=IDLE, TX_OUT=1, Busy=0, and clear the bit counter and the latched data and configuration.
REQ-021 SHALL abort a frame on reset mid-frame; TX_OUT=1 and Busy=0 from the next edge, and no partial frame resumes.

Configuration
REQ-022 SHALL emit exactly one stop bit when macro UART_TX_STOP2_EN is undefined.
REQ-023 SHALL emit two consecutive stop bits when UART_TX_STOP2_EN is defined, with Busy held high through both.

Structure
REQ-024 SHALL place the FSM state typedef and the IDLE_BIT=1, START_BIT=0 and STOP_BIT=1 constants in shared package uart_pkg.
REQ-025 SHALL use one sub-module, tx_parity_calc, that combinationally computes parity from the latched data and latched PAR_TYP.

Verification
REQ-026 SHALL cover: P_DATA=0xA5, PAR_EN=0, one DATA_VALID pulse -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 then idle 1; Busy high for exactly 10 cycles.
REQ-027 SHALL cover: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0; with PAR_TYP=1 -> parity bit 1; Busy high for 11 cycles.
REQ-028 SHALL cover: DATA_VALID held high with P_DATA changing to 0x3C mid-frame -> first frame still 0xA5; 0x3C is sent after one idle cycle.
REQ-029 SHALL cover: RST=0 during data bit 3 -> TX_OUT=1 and Busy=0 at the next edge; a following 0xFF request transmits correctly.
REQ-030 SHALL cover: P_DATA=0x00 and 0xFF with PAR_EN=1, PAR_TYP=1 -> parity 1 and 1; under UART_TX_STOP2_EN the frame has two stop bits and Busy is high for 12 cycles.
